ctrl_seq_unit: RTL

- Hardwired control sequencer that drives the datapath's control strobes.
- Fetches an instruction, decodes IR, and steps through T0..T6 to execute register-register ALU, unary ALU, and MUL/DIV instructions.
- Produces the same one-hot register-select and unit-strobe signals the benches currently drive by hand.
- Sits between the datapath and the memory interface.

---
 rtl/ctrl_pkg.sv | 132 +++++++++++++
 rtl/ctrl_seq_unit_reg_sel_decoder.sv | 22 ++
 rtl/ctrl_seq_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encodings,
// opcode constants, IR field positions, the strobe bundle and helper functions.
// No ports; imported by ctrl_seq_unit and reg_sel_decoder.
package ctrl_pkg;

  // IR field positions
  localparam int IR_OPC_MSB = 31;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_MSB  = 18;
  localparam int IR_RC_LSB  = 15;
  localparam int REG_SEL_W  = 4;

  // Opcodes
  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_ROR  = 5'b01001;
  localparam logic [4:0] OPC_ROL  = 5'b01010;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU3,
    C_UNARY,
    C_MULDIV,
    C_HALT
  } class_e;

  // Registered strobes. rout_rc / rin_ra / alu_en are enables whose data
  // (register field, opcode) is taken from the live IR.
  typedef struct packed {
    logic pcout;
    logic pcin;
    logic incpc;
    logic marin;
    logic mdrin;
    logic mdrout;
    logic mdrread;
    logic irin;
    logic zin;
    logic zloout;
    logic zhiout;
    logic hiin;
    logic loin;
    logic rout_rc;
    logic rin_ra;
    logic alu_en;
    logic halted;
  } strobe_t;

  function automatic class_e classify(input logic [4:0] opc);
    case (opc)
      OPC_NOP:                                   return C_NOP;
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL:        return C_ALU3;
      OPC_NEG, OPC_NOT:                          return C_UNARY;
      OPC_MUL, OPC_DIV:                          return C_MULDIV;
      default:                                   return C_HALT;  // HALT and every unknown opcode
    endcase
  endfunction

  function automatic state_e next_state(input state_e st, input class_e cls,
                                        input logic run_en, input logic mem_rdy);
    case (st)
      S_IDLE: return run_en ? S_T0 : S_IDLE;
      S_T0:   return S_T1;
      S_T1:   return mem_rdy ? S_T2 : S_T1;
      S_T2:   return S_T3;
      S_T3: begin
        case (cls)
          C_NOP:   return run_en ? S_T0 : S_IDLE;
          C_HALT:  return S_HALT;
          C_UNARY: return S_T5;
          default: return S_T4;
        endcase
      end
      S_T4:   return S_T5;
      S_T5:   return (cls == C_MULDIV) ? S_T6 : (run_en ? S_T0 : S_IDLE);
      S_T6:   return run_en ? S_T0 : S_IDLE;
      S_HALT: return S_HALT;
      default: return S_IDLE;
    endcase
  endfunction

  // Strobes to present while in state st. T3 is all zero here because its
  // strobes depend on the class of the freshly loaded IR and are formed
  // in the top from the live IR.
  function automatic strobe_t strobes_for(input state_e st, input class_e cls);
    strobe_t s;
    s = '0;
    case (st)
      S_T0: begin s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; s.zin = 1'b1; end
      S_T1: begin s.zloout = 1'b1; s.pcin = 1'b1; s.mdrread = 1'b1; s.mdrin = 1'b1; end
      S_T2: begin s.mdrout = 1'b1; s.irin = 1'b1; end
      S_T4: begin s.rout_rc = 1'b1; s.alu_en = 1'b1; s.zin = 1'b1; end
      S_T5: begin
        s.zloout = 1'b1;
        if (cls == C_MULDIV) s.loin = 1'b1;
        else                 s.rin_ra = 1'b1;
      end
      S_T6:   begin s.zhiout = 1'b1; s.hiin = 1'b1; end
      S_HALT: s.halted = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_seq_unit_reg_sel_decoder.sv
// Purpose: register-field to one-hot select decoder; all zero when disabled.
// Latency: combinational.  Backpressure: none.
// Ports: i_en enable, i_sel register number, o_onehot one-hot select.
module reg_sel_decoder
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = REG_SEL_W
) (
  input  logic                i_en,
  input  logic [SEL_W-1:0]    i_sel,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_en && (i_sel == SEL_W'(i))) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Purpose: hardwired control sequencer, fetch/decode/execute T0..T6 for ALU3, UNARY, MUL/DIV.
// Latency: ALU3 6, UNARY 5, MUL/DIV 7 cycles; +1 per cycle of i_mem_rdy=0 in T1.
// Backpressure: stalls in T1 until i_mem_rdy; i_run_en gates the next fetch only.
// Ports: i_clk/i_clr (sync active-high), i_run_en, i_ir, i_mem_rdy in;
//        o_rin/o_rout one-hot selects, datapath strobes, o_alu_opcode, o_halted, o_state_dbg out.
module ctrl_seq_unit
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic                i_run_en,
  input  logic [31:0]         i_ir,
  input  logic                i_mem_rdy,
  output logic [NUM_REGS-1:0] o_rin,
  output logic [NUM_REGS-1:0] o_rout,
  output logic                o_pcout,
  output logic                o_pcin,
  output logic                o_incpc,
  output logic                o_marin,
  output logic                o_mdrin,
  output logic                o_mdrout,
  output logic                o_mdrread,
  output logic                o_irin,
  output logic                o_yin,
  output logic                o_zin,
  output logic                o_zloout,
  output logic                o_zhiout,
  output logic                o_hiin,
  output logic                o_loin,
  output logic [OPC_W-1:0]    o_alu_opcode,
  output logic                o_halted,
  output logic [3:0]          o_state_dbg
);

  state_e  r_state;
  strobe_t r_stb;

  logic [OPC_W-1:0]     w_opc;
  logic [REG_SEL_W-1:0] w_ra, w_rb, w_rc;
  class_e               w_cls;
  state_e               w_next;
  logic                 w_t3, w_t3_act, w_t3_un;
  logic                 w_rout_en;
  logic [REG_SEL_W-1:0] w_rout_sel;
  logic                 w_unused;

  assign w_opc    = i_ir[IR_OPC_MSB -: OPC_W];
  assign w_ra     = i_ir[IR_RA_MSB:IR_RA_LSB];
  assign w_rb     = i_ir[IR_RB_MSB:IR_RB_LSB];
  assign w_rc     = i_ir[IR_RC_MSB:IR_RC_LSB];
  assign w_unused = ^i_ir[IR_RC_LSB-1:0];

  assign w_cls  = classify(w_opc);
  assign w_next = next_state(r_state, w_cls, i_run_en, i_mem_rdy);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= S_IDLE;
      r_stb   <= '0;
    end else begin
      r_state <= w_next;
      r_stb   <= strobes_for(w_next, w_cls);
    end
  end

  // IR is only written at the end of T2, so T3 strobes cannot be decided at
  // the edge entering T3; they are qualified by the registered state instead.
  assign w_t3     = (r_state == S_T3);
  assign w_t3_un  = w_t3 && (w_cls == C_UNARY);
  assign w_t3_act = w_t3 && ((w_cls == C_ALU3) || (w_cls == C_MULDIV) || (w_cls == C_UNARY));

  assign w_rout_en  = w_t3_act || r_stb.rout_rc;
  assign w_rout_sel = w_t3 ? w_rb : w_rc;

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_rout_dec (
    .i_en     (w_rout_en),
    .i_sel    (w_rout_sel),
    .o_onehot (o_rout)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_rin_dec (
    .i_en     (r_stb.rin_ra),
    .i_sel    (w_ra),
    .o_onehot (o_rin)
  );

  assign o_pcout      = r_stb.pcout;
  assign o_pcin       = r_stb.pcin;
  assign o_incpc      = r_stb.incpc;
  assign o_marin      = r_stb.marin;
  assign o_mdrin      = r_stb.mdrin;
  assign o_mdrout     = r_stb.mdrout;
  assign o_mdrread    = r_stb.mdrread;
  assign o_irin       = r_stb.irin;
  assign o_yin        = w_t3_act && !w_t3_un;
  assign o_zin        = r_stb.zin || w_t3_un;
  assign o_zloout     = r_stb.zloout;
  assign o_zhiout     = r_stb.zhiout;
  assign o_hiin       = r_stb.hiin;
  assign o_loin       = r_stb.loin;
  assign o_alu_opcode = (w_t3_un || r_stb.alu_en) ? w_opc : '0;
  assign o_halted     = r_stb.halted;
  assign o_state_dbg  = r_state;

endmodule
